// File: rtl/multiple_detector_serial_pkg.sv
// multiple_detector_serial_pkg: flag indices, state encoding and flag decode shared by the serial detector
package multiple_detector_serial_pkg;
  localparam int FLAG_X2 = 0;
  localparam int FLAG_X3 = 1;
  localparam int FLAG_X4 = 2;
  localparam int FLAG_X5 = 3;
  localparam int FLAG_X30 = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, SHIFT = ST_SHIFT, DONE = ST_DONE} state_e;
  // Zero has no shifted-in one bit, so nz masks every flag off to match the legacy table.
  function automatic logic [4:0] flags_of(input logic [1:0] l2, input logic nz, input logic r3z, input logic r5z);
    logic [4:0] f;
    f[FLAG_X2] = ~l2[0];
    f[FLAG_X3] = r3z;
    f[FLAG_X4] = ~|l2;
    f[FLAG_X5] = r5z;
    f[FLAG_X30] = ~l2[0] & r3z & r5z;
    return f & {5{nz}};
  endfunction
endpackage

// File: rtl/multiple_detector_serial_if.sv
// multiple_detector_serial_if: valid/ready word input and flag/value result channel
interface multiple_detector_serial_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [4:0] out_flags;
  logic [WIDTH-1:0] out_value;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_flags, out_value);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_flags, out_value);
endinterface

// File: rtl/multiple_detector_serial_residue.sv
// residue_step: MSB-first serial mod-M accumulator, exposes the residue after the current bit
module residue_step #(
  parameter int M = 3,
  localparam int RW = $clog2(M)
) (
  input logic clk,
  input logic rst,
  input logic clr_i,
  input logic en_i,
  input logic b_i,
  output logic [RW-1:0] r_next_o
);
  logic [RW-1:0] r_q;
  logic [RW:0] sum;
  logic [RW:0] dif;
  assign sum = {r_q, b_i};
  assign dif = sum - (RW+1)'(M);
  // 2r+b < 2M, so a single conditional subtract keeps the residue in 0..M-1
  always_comb r_next_o = clr_i ? '0 : !en_i ? r_q : (sum >= (RW+1)'(M)) ? dif[RW-1:0] : sum[RW-1:0];
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else r_q <= r_next_o;
  end
endmodule

// File: rtl/multiple_detector_serial.sv
// multiple_detector_serial: serial MSB-first multiple-of-2/3/4/5/30 detector with valid/ready and hit counter
module multiple_detector_serial
  import multiple_detector_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  multiple_detector_serial_if.slave bus,
  output logic [CNT_W-1:0] hit30_count_o
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] lsb2_q, lsb2_d;
  logic nz_q, nz_d;
  logic [4:0] flags_q, flags_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic clr, en, b;
  logic [1:0] r3_n;
  logic [2:0] r5_n;
  assign b = sh_q[WIDTH-1];
  residue_step #(.M(3)) u_r3 (.clk(clk), .rst(rst), .clr_i(clr), .en_i(en), .b_i(b), .r_next_o(r3_n));
  residue_step #(.M(5)) u_r5 (.clk(clk), .rst(rst), .clr_i(clr), .en_i(en), .b_i(b), .r_next_o(r5_n));
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    val_d = val_q;
    cnt_d = cnt_q;
    lsb2_d = lsb2_q;
    nz_d = nz_q;
    flags_d = flags_q;
    hit_d = hit_q;
    clr = 1'b0;
    en = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = SHIFT;
        sh_d = bus.in_data;
        val_d = bus.in_data;
        cnt_d = CW'(WIDTH - 1);
        lsb2_d = '0;
        nz_d = 1'b0;
        clr = 1'b1;
      end
      SHIFT: begin
        en = 1'b1;
        sh_d = sh_q << 1;
        lsb2_d = {lsb2_q[0], b};
        nz_d = nz_q | b;
        cnt_d = cnt_q - 1'b1;
        // Flags latch from the post-shift values so DONE presents them immediately
        if (cnt_q == '0) begin
          state_d = DONE;
          flags_d = flags_of(lsb2_d, nz_d, r3_n == '0, r5_n == '0);
        end
      end
      DONE: if (bus.out_ready) begin
        state_d = IDLE;
        hit_d = hit_q + CNT_W'(flags_q[FLAG_X30] & ~&hit_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      val_q <= '0;
      cnt_q <= '0;
      lsb2_q <= '0;
      nz_q <= 1'b0;
      flags_q <= '0;
      hit_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
      lsb2_q <= lsb2_d;
      nz_q <= nz_d;
      flags_q <= flags_d;
      hit_q <= hit_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_flags = flags_q;
  assign bus.out_value = val_q;
  assign hit30_count_o = hit_q;
endmodule

// File: tb/tb_multiple_detector_serial.sv
// tb_multiple_detector_serial: directed checks of the serial detector at WIDTH=5, WIDTH=8 and CNT_W=2
module tb_multiple_detector_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [7:0] c5, c8;
  logic [1:0] cc;
  multiple_detector_serial_if #(.WIDTH(5)) i5 ();
  multiple_detector_serial_if #(.WIDTH(8)) i8 ();
  multiple_detector_serial_if #(.WIDTH(5)) ic ();
  multiple_detector_serial #(.WIDTH(5), .CNT_W(8)) u5 (.clk(clk), .rst(rst), .bus(i5), .hit30_count_o(c5));
  multiple_detector_serial #(.WIDTH(8), .CNT_W(8)) u8 (.clk(clk), .rst(rst), .bus(i8), .hit30_count_o(c8));
  multiple_detector_serial #(.WIDTH(5), .CNT_W(2)) uc (.clk(clk), .rst(rst), .bus(ic), .hit30_count_o(cc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] legacy(input int x);
    logic [4:0] f;
    f = {x % 30 == 0, x % 5 == 0, x % 4 == 0, x % 3 == 0, x % 2 == 0};
    return x == 0 ? 5'b0 : f;
  endfunction
  task automatic set_in(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin i5.in_valid = v; i5.in_data = d[4:0]; end
    else if (s == 1) begin i8.in_valid = v; i8.in_data = d; end
    else begin ic.in_valid = v; ic.in_data = d[4:0]; end
  endtask
  function automatic logic ov(input int s);
    return s == 0 ? i5.out_valid : s == 1 ? i8.out_valid : ic.out_valid;
  endfunction
  function automatic logic ir(input int s);
    return s == 0 ? i5.in_ready : s == 1 ? i8.in_ready : ic.in_ready;
  endfunction
  function automatic logic [4:0] fl(input int s);
    return s == 0 ? i5.out_flags : s == 1 ? i8.out_flags : ic.out_flags;
  endfunction
  function automatic logic [7:0] vl(input int s);
    return s == 0 ? {3'b0, i5.out_value} : s == 1 ? i8.out_value : {3'b0, ic.out_value};
  endfunction
  function automatic logic [7:0] cn(input int s);
    return s == 0 ? c5 : s == 1 ? c8 : {6'b0, cc};
  endfunction
  task automatic xfer(input int s, input logic [7:0] d, input logic acc, output logic [4:0] f, output logic [7:0] v, output int lat);
    set_in(s, 1'b1, d);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      set_in(s, 1'b0, d);
      if (ov(s)) lat = n;
    end
    if (lat == 0) chk("timeout", 0, 1);
    f = fl(s);
    v = vl(s);
    if (acc) begin @(posedge clk); #1; end
  endtask
  initial begin
    logic [4:0] f;
    logic [7:0] v;
    int lat, hits;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'd0);
    i5.out_ready = 1'b1; i8.out_ready = 1'b1; ic.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", ir(0), 1);
    chk("rst_out_valid", ov(0), 0);
    chk("rst_flags", fl(0), 0);
    chk("rst_value", vl(0), 0);
    chk("rst_count", cn(0), 0);
    xfer(0, 8'd30, 1'b1, f, v, lat);
    chk("w5_30_flags", f, 5'b11011);
    chk("w5_30_value", v, 30);
    chk("w5_30_latency", lat, 6);
    chk("w5_30_count", cn(0), 1);
    chk("w5_idle_after", ir(0), 1);
    xfer(0, 8'd0, 1'b1, f, v, lat);
    chk("w5_0_flags", f, 5'b00000);
    xfer(0, 8'd12, 1'b1, f, v, lat);
    chk("w5_12_flags", f, 5'b00111);
    for (int x = 0; x < 32; x++) begin
      xfer(0, 8'(x), 1'b1, f, v, lat);
      chk($sformatf("sweep_%0d", x), f, legacy(x));
    end
    chk("w5_count_sweep", cn(0), 2);
    xfer(1, 8'd240, 1'b1, f, v, lat);
    chk("w8_240", f, 5'b11111);
    chk("w8_240_latency", lat, 9);
    xfer(1, 8'd255, 1'b1, f, v, lat);
    chk("w8_255", f, 5'b01010);
    xfer(1, 8'd7, 1'b1, f, v, lat);
    chk("w8_7", f, 5'b00000);
    i8.out_ready = 1'b0;
    xfer(1, 8'd240, 1'b0, f, v, lat);
    for (int k = 0; k < 10; k++) begin
      set_in(1, k[0], 8'd3);
      @(posedge clk); #1;
      chk("bp_hold", {ov(1), ir(1), fl(1), vl(1)}, {2'b10, 5'b11111, 8'd240});
    end
    set_in(1, 1'b0, 8'd0);
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {ov(1), ir(1)}, 2'b01);
    @(posedge clk); #1;
    chk("bp_no_queue", ov(1), 0);
    xfer(1, 8'd12, 1'b1, f, v, lat);
    chk("bp_next", {f, v}, {5'b00111, 8'd12});
    set_in(0, 1'b1, 8'd31);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", ir(0), 1);
    chk("mid_rst_valid", ov(0), 0);
    chk("mid_rst_count", cn(0), 0);
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ov(0)) hits++;
    end
    chk("mid_rst_no_pulse", hits, 0);
    xfer(0, 8'd30, 1'b1, f, v, lat);
    chk("mid_rst_next", {f, v}, {5'b11011, 8'd30});
    for (int k = 1; k <= 4; k++) begin
      xfer(2, 8'd30, 1'b1, f, v, lat);
      chk($sformatf("sat_%0d", k), cn(2), k > 3 ? 3 : k);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
